// File: rtl/uart_host_bridge.sv
// uart_host_bridge: drives an ASCII hex command protocol ("L"+addr, "W"/"R", data) over a UART and decodes read replies.
// Optional address cache enabled by defining UART_HOST_ADDR_CACHE_EN.
`default_nettype none

module uart_host_bridge #(
    parameter int RX_TIMEOUT = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_dat,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_dat,
    input  logic        i_uart_send_ready,
    output logic        o_uart_send_pulse,
    output logic [7:0]  o_uart_dat,
    input  logic        i_uart_received_pulse,
    input  logic [7:0]  i_uart_dat
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND_L    = 3'd1;
    localparam logic [2:0] SEND_ADDR = 3'd2;
    localparam logic [2:0] SEND_CMD  = 3'd3;
    localparam logic [2:0] SEND_DATA = 3'd4;
    localparam logic [2:0] WAIT_RX   = 3'd5;
    localparam logic [2:0] FINISH    = 3'd6;

    localparam logic [15:0] TMO_LAST = 16'(RX_TIMEOUT - 1);

    logic [2:0]  state;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic [1:0]  nib;
    logic        prev_pulse;
    logic        err_q;
    logic [7:0]  rd_dat;
    logic [3:0]  rx_hi;
    logic        rx_half;
    logic [15:0] tmo_cnt;

    logic        sending;
    logic [7:0]  tx_char;
    logic        fire;
    logic        rx_ok;
    logic [3:0]  rx_nib;
    logic        rx_fail;
    logic        hit;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    always_comb begin
        sending = 1'b0;
        tx_char = 8'h00;
        case (state)
            SEND_L: begin
                sending = 1'b1;
                tx_char = 8'h4c;
            end
            SEND_ADDR: begin
                sending = 1'b1;
                tx_char = hex_char(addr[{nib, 2'b00} +: 4]);
            end
            SEND_CMD: begin
                sending = 1'b1;
                tx_char = we ? 8'h57 : 8'h52;
            end
            SEND_DATA: begin
                sending = 1'b1;
                tx_char = hex_char(nib[0] ? wdat[7:4] : wdat[3:0]);
            end
            default: begin
                sending = 1'b0;
                tx_char = 8'h00;
            end
        endcase
    end

    // A pulse is never issued back-to-back, giving the transmitter a cycle to drop ready.
    assign fire = sending && i_uart_send_ready && !prev_pulse && !i_reset;

    always_comb begin
        rx_ok  = 1'b0;
        rx_nib = 4'h0;
        if (i_uart_dat >= 8'h30 && i_uart_dat <= 8'h39) begin
            rx_ok  = 1'b1;
            rx_nib = i_uart_dat[3:0];
        end else if (i_uart_dat >= 8'h61 && i_uart_dat <= 8'h66) begin
            rx_ok  = 1'b1;
            rx_nib = i_uart_dat[3:0] + 4'd9;
        end
    end

    assign rx_fail = (state == WAIT_RX) &&
                     (i_uart_received_pulse ? !rx_ok : (tmo_cnt == TMO_LAST));

`ifdef UART_HOST_ADDR_CACHE_EN
    logic [15:0] exp_addr;
    logic        cache_valid;

    // In FINISH the cache update is still in flight, so compare against the successor directly.
    assign hit = (state == FINISH) ? (i_addr == addr + 16'd1)
                                   : (cache_valid && i_addr == exp_addr);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            exp_addr    <= 16'h0000;
            cache_valid <= 1'b0;
        end else if (rx_fail) begin
            cache_valid <= 1'b0;
        end else if (state == FINISH) begin
            exp_addr    <= addr + 16'd1;
            cache_valid <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            we         <= 1'b0;
            addr       <= 16'h0000;
            wdat       <= 8'h00;
            nib        <= 2'd0;
            prev_pulse <= 1'b0;
            err_q      <= 1'b0;
            rd_dat     <= 8'h00;
            rx_hi      <= 4'h0;
            rx_half    <= 1'b0;
            tmo_cnt    <= 16'h0000;
        end else begin
            prev_pulse <= fire;
            err_q      <= rx_fail;
            case (state)
                IDLE, FINISH: begin
                    if (i_req) begin
                        we    <= i_we;
                        addr  <= i_addr;
                        wdat  <= i_dat;
                        nib   <= 2'd0;
                        state <= hit ? SEND_CMD : SEND_L;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND_L: begin
                    if (fire) begin
                        nib   <= 2'd0;
                        state <= SEND_ADDR;
                    end
                end
                SEND_ADDR: begin
                    if (fire) begin
                        nib <= nib + 2'd1;
                        if (nib == 2'd3) state <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (fire) begin
                        nib     <= 2'd0;
                        tmo_cnt <= 16'h0000;
                        rx_half <= 1'b0;
                        state   <= we ? SEND_DATA : WAIT_RX;
                    end
                end
                SEND_DATA: begin
                    if (fire) begin
                        nib <= nib + 2'd1;
                        if (nib == 2'd1) state <= FINISH;
                    end
                end
                WAIT_RX: begin
                    if (rx_fail) begin
                        state <= IDLE;
                    end else if (i_uart_received_pulse) begin
                        tmo_cnt <= 16'h0000;
                        if (!rx_half) begin
                            rx_hi   <= rx_nib;
                            rx_half <= 1'b1;
                        end else begin
                            rd_dat <= {rx_hi, rx_nib};
                            state  <= FINISH;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy            = (state != IDLE) && (state != FINISH);
    assign o_done            = (state == FINISH) && !i_reset;
    assign o_err             = err_q;
    assign o_dat             = rd_dat;
    assign o_uart_send_pulse = fire;
    assign o_uart_dat        = sending ? tx_char : 8'h00;

endmodule

`default_nettype wire
